bilinear_seq: RTL and testbench
===============================

Name: bilinear_seq

Overview:
Initiator side of the bilinear_interp start/valid interface. For each destination pixel it:
- computes Q8.8 source coordinates;
- fetches the four neighbour pixels from the source image RAM;
- drives p1..p4/wx/wy with a one-cycle start pulse into bilinear_interp;
- waits for valid and writes the result into the destination image RAM.

It sits between the frame buffers and bilinear_interp in the downscaling datapath.

Parameters:
- SRC_W, 64, source image width in pixels
- SRC_H, 64, source image height in pixels
- ADDR_W, 16, read/write RAM address width (must hold SRC_W*SRC_H-1)
- DIM_W, 8, width of destination dimension inputs
- TIMEOUT, 64, cycles to wait for i_valid (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_go  in  1  one-cycle pulse: start a frame (ignored while o_busy)
- i_step  in  16  Q8.8 source step per destination pixel (0x0200 = 2x downscale)
- i_dst_w  in  DIM_W  destination width (>=1)
- i_dst_h  in  DIM_W  destination height (>=1)
- o_rd_addr  out  ADDR_W  source RAM read address; data valid 1 cycle later
- i_rd_data  in  8  source RAM read data
- o_p1, o_p2, o_p3, o_p4  out  8 each  neighbours (x0,y0), (x1,y0), (x0,y1), (x1,y1)
- o_wx, o_wy  out  16  Q8.8 fractions, integer byte always 0
- o_start  out  1  one-cycle start pulse to bilinear_interp
- i_pixel  in  8  interpolated result
- i_valid  in  1  result valid
- o_wr_en  out  1  destination RAM write strobe
- o_wr_addr  out  ADDR_W  destination address = dy*i_dst_w + dx
- o_wr_data  out  8  pixel written
- o_busy  out  1  high from the cycle after accepted i_go until DONE
- o_done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters dx=dy=0. Asserting reset mid-frame aborts immediately; no further writes occur.
- i_dst_w, i_dst_h and i_step are latched on accepted i_go and held for the frame.
- Coordinates:
  - xf = dx*step, 16 bit (accumulated by adding step, not multiplied); yf likewise.
  - x0 = xf[15:8], fx = xf[7:0].
  - If x0 > SRC_W-1, x0 = SRC_W-1 and fx = 0.
  - x1 = min(x0+1, SRC_W-1). Same rules for y with SRC_H.
- Source address = y*SRC_W + x.
- FSM states:
  - IDLE: on i_go -> CALC.
  - CALC: 1 cycle, register x0/x1/y0/y1/fx/fy.
  - FETCH: 4 cycles, issue addresses for p1, p2, p3, p4 in order; capture i_rd_data one cycle after each issue.
  - DRAIN: 1 cycle, capture p4.
  - START: o_start=1 for exactly 1 cycle; p*/wx/wy are stable from START until the next CALC.
  - WAIT: hold until i_valid.
  - WRITE: o_wr_en=1, o_wr_data = i_pixel captured in WAIT; 1 cycle.
  - WRITE transition: if dx<dst_w-1 then dx++ and -> CALC; else if dy<dst_h-1 then dx=0, dy++ and -> CALC; else -> DONE.
  - DONE: o_done=1 for 1 cycle, o_busy drops the same cycle, -> IDLE.
- Latency per pixel = 8 cycles + interp latency.
- i_valid outside WAIT is ignored.
- i_go while busy is ignored.
- step=0: every destination pixel samples (0,0).

Optional Feature:
BILINEAR_SEQ_TIMEOUT_EN
- Defined: a counter runs in WAIT. If i_valid has not arrived after TIMEOUT cycles, write 0x00, set sticky output o_err (1 bit, cleared on i_go) and continue with the next pixel.
- Undefined: WAIT blocks indefinitely and the o_err port does not exist.

Decomposition:
- downscale_pkg:
  - pixel_t (logic [7:0]), q88_t (logic [15:0]);
  - seq_state_t enum (IDLE, CALC, FETCH, DRAIN, START, WAIT, WRITE, DONE);
  - Q8.8 helper constants FRAC_BITS=8 and ONE_Q88=16'h0100.
- Sub-module coord_gen: step accumulator plus clamp/x1 logic per axis, instantiated twice (x with SRC_W, y with SRC_H).

Test Plan:
Bench = bilinear_seq + real bilinear_interp + 4x4 source RAM model, src(x,y) = 16*y + 4*x, SRC_W=SRC_H=4.
- Basic frame: step=0x0180, dst 2x2, i_go -> writes addr0=0, addr1=6, addr2=24, addr3=30 in order; exactly 4 o_wr_en; o_done one cycle after the last write; o_busy low after.
- Edge clamp: step=0x0300, dst 2x1 -> pixel 1 fetches p1=p2=12 (x0=x1=3), writes 12 at addr1.
- Handshake: interp stub delays i_valid 10 cycles and pulses spurious i_valid during FETCH -> spurious pulse ignored; o_start is exactly 1 cycle per pixel; p*/wx/wy stable until write.
- Reset mid-frame: assert rst_n=0 after 2 writes of a 2x2 frame -> all outputs 0 during reset; no further o_wr_en; new i_go after release completes all 4 writes correctly.
- i_go while busy: second i_go during WAIT -> ignored; exactly one o_done per frame.
- Timeout (BILINEAR_SEQ_TIMEOUT_EN, TIMEOUT=16): stub never asserts i_valid -> each pixel writes 0 about 16 cycles after o_start; o_err=1 until the next i_go.

Source files
------------

// File: rtl/downscale_pkg.sv
// Shared types and constants for the downscaling datapath.
// Latency: none (types and constants only).
// Backpressure: none.
package downscale_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [15:0] q88_t;

  typedef enum logic [2:0] {
    IDLE, CALC, FETCH, DRAIN, START, WAIT, WRITE, DONE
  } seq_state_t;

  localparam int   FRAC_BITS = 8;
  localparam q88_t ONE_Q88   = 16'h0100;

endpackage

// File: rtl/bilinear_seq_if.sv
// Start/valid link between bilinear_seq (master) and bilinear_interp (slave).
// Latency: wires only; the slave answers a start pulse with valid some cycles later.
// Backpressure: none; the master holds its operands until valid returns.
interface bilinear_seq_if;
  import downscale_pkg::*;

  pixel_t o_p1;
  pixel_t o_p2;
  pixel_t o_p3;
  pixel_t o_p4;
  q88_t   o_wx;
  q88_t   o_wy;
  logic   o_start;
  pixel_t i_pixel;
  logic   i_valid;

  modport master (
    output o_p1, o_p2, o_p3, o_p4, o_wx, o_wy, o_start,
    input  i_pixel, i_valid
  );

  modport slave (
    input  o_p1, o_p2, o_p3, o_p4, o_wx, o_wy, o_start,
    output i_pixel, i_valid
  );

endinterface

// File: rtl/coord_gen.sv
// One-axis Q8.8 coordinate generator: step accumulator with edge clamp and neighbour index.
// Latency: coordinates are combinational from the accumulator register.
// Backpressure: none; the accumulator moves only on clr_i / adv_i.
module coord_gen
  import downscale_pkg::*;
#(
  parameter int SRC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       adv_i,
  input  q88_t       step_i,
  output logic [7:0] c0_o,
  output logic [7:0] c1_o,
  output logic [7:0] frac_o
);

  localparam logic [7:0] MAX_C = 8'(SRC - 1);

  q88_t acc_d;
  q88_t acc_q;
  q88_t nxt;

  // Accumulate the step instead of multiplying by the destination index
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (adv_i) begin
      acc_d = acc_q + step_i;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Clamp past the image edge (fraction dropped) and pick the right/lower neighbour
  always_comb begin
    c0_o   = acc_q[15:FRAC_BITS];
    frac_o = acc_q[FRAC_BITS-1:0];
    if (acc_q[15:FRAC_BITS] > MAX_C) begin
      c0_o   = MAX_C;
      frac_o = '0;
    end
    nxt  = {c0_o, 8'h00} + ONE_Q88;
    c1_o = (c0_o < MAX_C) ? nxt[15:FRAC_BITS] : MAX_C;
  end

endmodule

// File: rtl/bilinear_seq.sv
// Walks the destination raster, fetches 4 source neighbours, starts the interpolator, writes results.
// Latency: 8 cycles per pixel plus interpolator latency; one pixel in flight at a time.
// Backpressure: stalls in WAIT until valid (optional macro BILINEAR_SEQ_TIMEOUT_EN bounds the wait).
module bilinear_seq
  import downscale_pkg::*;
#(
  parameter int SRC_W  = 64,
  parameter int SRC_H  = 64,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
`ifdef BILINEAR_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_go,
  input  q88_t              i_step,
  input  logic [DIM_W-1:0]  i_dst_w,
  input  logic [DIM_W-1:0]  i_dst_h,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  pixel_t            i_rd_data,
  bilinear_seq_if.master    ifc,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output pixel_t            o_wr_data,
  output logic              o_busy,
  output logic              o_done
`ifdef BILINEAR_SEQ_TIMEOUT_EN
  ,
  output logic              o_err
`endif
);

  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

  seq_state_t        state_q, state_d;
  logic [1:0]        fcnt_q;
  logic [DIM_W-1:0]  dst_w_q, dst_h_q, dx_q, dy_q;
  q88_t              step_q;
  logic [7:0]        x0_c, x1_c, fx_c, y0_c, y1_c, fy_c;
  logic [7:0]        x0_q, x1_q, fx_q, y0_q, y1_q, fy_q;
  logic [7:0]        xsel, ysel;
  pixel_t [3:0]      p_q;
  pixel_t            pix_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              accept, last_x, last_y, timed_out;
  logic              x_clr, x_adv, y_clr, y_adv;

  assign accept = i_go && (state_q == IDLE || state_q == DONE);
  assign last_x = !(dx_q < dst_w_q - DIM_W'(1));
  assign last_y = !(dy_q < dst_h_q - DIM_W'(1));

  coord_gen #(.SRC(SRC_W)) u_x (
    .clk(clk), .rst_n(rst_n), .clr_i(x_clr), .adv_i(x_adv), .step_i(step_q),
    .c0_o(x0_c), .c1_o(x1_c), .frac_o(fx_c)
  );

  coord_gen #(.SRC(SRC_H)) u_y (
    .clk(clk), .rst_n(rst_n), .clr_i(y_clr), .adv_i(y_adv), .step_i(step_q),
    .c0_o(y0_c), .c1_o(y1_c), .frac_o(fy_c)
  );

`ifdef BILINEAR_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  assign timed_out = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign o_err     = err_q;

  // Count WAIT cycles; the error flag stays up until the next accepted frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == WAIT) ? tmo_q + TMO_W'(1) : '0;
      if (accept) begin
        err_q <= 1'b0;
      end else if (state_q == WAIT && timed_out && !ifc.i_valid) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus raster-walk strobes for the coordinate generators
  always_comb begin
    state_d = state_q;
    x_clr   = accept;
    y_clr   = accept;
    x_adv   = 1'b0;
    y_adv   = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = CALC;
      CALC:  state_d = FETCH;
      FETCH: if (fcnt_q == 2'd3) state_d = DRAIN;
      DRAIN: state_d = START;
      START: state_d = WAIT;
      WAIT:  if (ifc.i_valid || timed_out) state_d = WRITE;
      WRITE: begin
        if (!last_x) begin
          x_adv   = 1'b1;
          state_d = CALC;
        end else if (!last_y) begin
          x_clr   = 1'b1;
          y_adv   = 1'b1;
          state_d = CALC;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame parameters, raster counters, coordinates, fetched neighbours and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_w_q   <= '0;
      dst_h_q   <= '0;
      step_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      fcnt_q    <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      fx_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      fy_q      <= '0;
      p_q       <= '0;
      pix_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      if (accept) begin
        dst_w_q   <= i_dst_w;
        dst_h_q   <= i_dst_h;
        step_q    <= i_step;
        wr_addr_q <= '0;
      end
      if (x_clr)      dx_q <= '0;
      else if (x_adv) dx_q <= dx_q + DIM_W'(1);
      if (y_clr)      dy_q <= '0;
      else if (y_adv) dy_q <= dy_q + DIM_W'(1);
      if (state_q == CALC) begin
        x0_q <= x0_c;
        x1_q <= x1_c;
        fx_q <= fx_c;
        y0_q <= y0_c;
        y1_q <= y1_c;
        fy_q <= fy_c;
      end
      fcnt_q <= (state_q == FETCH) ? fcnt_q + 2'd1 : 2'd0;
      // RAM data trails the address by one cycle, so capture the previous issue
      if (state_q == FETCH && fcnt_q != 2'd0) p_q[fcnt_q - 2'd1] <= i_rd_data;
      if (state_q == DRAIN) p_q[3] <= i_rd_data;
      if (state_q == WAIT) pix_q <= ifc.i_valid ? ifc.i_pixel : 8'h00;
      if (state_q == WRITE) wr_addr_q <= wr_addr_q + ADDR_W'(1);
    end
  end

  // Neighbour order: (x0,y0), (x1,y0), (x0,y1), (x1,y1)
  assign xsel      = fcnt_q[0] ? x1_q : x0_q;
  assign ysel      = fcnt_q[1] ? y1_q : y0_q;
  assign o_rd_addr = (state_q == FETCH) ? ADDR_W'(ysel) * SRC_W_A + ADDR_W'(xsel) : '0;

  assign ifc.o_p1    = p_q[0];
  assign ifc.o_p2    = p_q[1];
  assign ifc.o_p3    = p_q[2];
  assign ifc.o_p4    = p_q[3];
  assign ifc.o_wx    = {8'h00, fx_q};
  assign ifc.o_wy    = {8'h00, fy_q};
  assign ifc.o_start = (state_q == START);

  assign o_wr_en   = (state_q == WRITE);
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = pix_q;
  assign o_busy    = (state_q != IDLE) && (state_q != DONE);
  assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_bilinear_seq.sv
// Directed bench: bilinear_seq with a 4x4 source RAM model and a behavioural interpolator.
// Source pixel (x,y) = 16*y + 4*x; expected writes are hand-computed constants.
// Interpolator latency, spurious valid and the no-response case are set per test.
module tb_bilinear_seq;
  import downscale_pkg::*;

  localparam int SRC_W  = 4;
  localparam int SRC_H  = 4;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_go = 1'b0;
  q88_t              i_step = '0;
  logic [DIM_W-1:0]  i_dst_w = 8'd1;
  logic [DIM_W-1:0]  i_dst_h = 8'd1;
  logic [ADDR_W-1:0] o_rd_addr;
  pixel_t            rd_data = '0;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  pixel_t            o_wr_data;
  logic              o_busy;
  logic              o_done;
`ifdef BILINEAR_SEQ_TIMEOUT_EN
  logic              o_err;
`endif

  bilinear_seq_if ifc ();

  bilinear_seq #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
`ifdef BILINEAR_SEQ_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_step(i_step),
    .i_dst_w(i_dst_w), .i_dst_h(i_dst_h),
    .o_rd_addr(o_rd_addr), .i_rd_data(rd_data), .ifc(ifc),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done)
`ifdef BILINEAR_SEQ_TIMEOUT_EN
    , .o_err(o_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Source RAM: one-cycle read latency
  always @(posedge clk) rd_data <= 8'((int'(o_rd_addr) / 4) * 16 + (int'(o_rd_addr) % 4) * 4);

  // Behavioural interpolator
  int     interp_lat = 3;
  bit     spur_en = 1'b0;
  bit     never_valid = 1'b0;
  int     lat_cnt;
  int     spur_cnt;
  pixel_t res;

  function automatic pixel_t interp(pixel_t a, pixel_t b, pixel_t c, pixel_t d, q88_t wx, q88_t wy);
    int fx, fy, top, bot;
    fx  = int'(wx[7:0]);
    fy  = int'(wy[7:0]);
    top = int'(a) * (256 - fx) + int'(b) * fx;
    bot = int'(c) * (256 - fx) + int'(d) * fx;
    return 8'((top * (256 - fy) + bot * fy) >> 16);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc.i_valid <= 1'b0;
      ifc.i_pixel <= '0;
      lat_cnt     <= 0;
      spur_cnt    <= 0;
      res         <= '0;
    end else begin
      ifc.i_valid <= 1'b0;
      if (ifc.o_start && !never_valid) begin
        lat_cnt <= interp_lat;
        res     <= interp(ifc.o_p1, ifc.o_p2, ifc.o_p3, ifc.o_p4, ifc.o_wx, ifc.o_wy);
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          ifc.i_valid <= 1'b1;
          ifc.i_pixel <= res;
        end
      end
      // Spurious valid lands in the first FETCH cycle of the next pixel
      if (spur_en && o_wr_en) begin
        spur_cnt <= 1;
      end else if (spur_cnt == 1) begin
        spur_cnt    <= 0;
        ifc.i_valid <= 1'b1;
        ifc.i_pixel <= 8'hEE;
      end
    end
  end

  // Output monitor
  int          wr_a[$];
  int          wr_d[$];
  int          n_done = 0, n_start = 0, start_multi = 0, unstable = 0;
  int          done_cyc = 0, last_wr_cyc = 0, start_cyc = 0;
  int          last_p1 = 0, last_p2 = 0, last_p4 = 0;
  bit          prev_start = 1'b0;
  logic [63:0] snap = '0;
  logic [63:0] cur;
  assign cur = {ifc.o_p1, ifc.o_p2, ifc.o_p3, ifc.o_p4, ifc.o_wx, ifc.o_wy};

  always @(negedge clk) begin
    if (o_wr_en) begin
      wr_a.push_back(int'(o_wr_addr));
      wr_d.push_back(int'(o_wr_data));
      last_wr_cyc = cyc;
      if (cur != snap) unstable++;
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (ifc.o_start) begin
      n_start++;
      if (prev_start) start_multi++;
      snap      = cur;
      start_cyc = cyc;
      last_p1   = int'(ifc.o_p1);
      last_p2   = int'(ifc.o_p2);
      last_p4   = int'(ifc.o_p4);
    end
    prev_start = ifc.o_start;
  end

  // Checking
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int base_wr, base_done, base_start, base_multi, base_unstable;

  task automatic go_pulse(input q88_t step, input int w, input int h);
    i_step  = step;
    i_dst_w = DIM_W'(w);
    i_dst_h = DIM_W'(h);
    i_go    = 1'b1;
    @(posedge clk); #1;
    i_go    = 1'b0;
  endtask

  task automatic run_frame(input q88_t step, input int w, input int h, input bit extra_go);
    int k;
    base_wr       = wr_d.size();
    base_done     = n_done;
    base_start    = n_start;
    base_multi    = start_multi;
    base_unstable = unstable;
    go_pulse(step, w, h);
    check_eq("busy_after_go", o_busy, 1);
    if (extra_go) begin
      k = 0;
      while (!ifc.o_start && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      check_eq("start_seen", k < 200, 1);
      @(posedge clk); #1;
      go_pulse(16'h0300, 3, 3);
    end
    k = 0;
    while (!o_done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("done_seen", k < 3000, 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("busy_after_done", o_busy, 0);
  endtask

  task automatic check_frame(input string tag, input int n, input int d0, input int d1,
                             input int d2, input int d3);
    int d[4];
    d = '{d0, d1, d2, d3};
    check_eq({tag, "_nwr"}, wr_d.size() - base_wr, n);
    for (int i = 0; i < n && base_wr + i < wr_d.size(); i++) begin
      check_eq({tag, "_addr"}, wr_a[base_wr + i], i);
      check_eq({tag, "_data"}, wr_d[base_wr + i], d[i]);
    end
    check_eq({tag, "_ndone"}, n_done - base_done, 1);
    check_eq({tag, "_done_lag"}, done_cyc - last_wr_cyc, 1);
    check_eq({tag, "_nstart"}, n_start - base_start, n);
    check_eq({tag, "_start_1cyc"}, start_multi - base_multi, 0);
    check_eq({tag, "_stable"}, unstable - base_unstable, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_wr_en", o_wr_en, 0);
    check_eq("rst_start", ifc.o_start, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.5x downscale, 2x2
    run_frame(16'h0180, 2, 2, 1'b0);
    check_frame("basic", 4, 0, 6, 24, 30);

    // Right edge: x0 = 3 so x1 clamps to 3
    run_frame(16'h0300, 2, 1, 1'b0);
    check_frame("edge", 2, 0, 12, 0, 0);
    check_eq("edge_p1", last_p1, 12);
    check_eq("edge_p2", last_p2, 12);

    // x0 = 5 past the edge: clamped to 3, fraction dropped
    run_frame(16'h0280, 3, 1, 1'b0);
    check_frame("clampx", 3, 0, 10, 12, 0);

    // y clamp: rows 0, 2, then 4 -> 3
    run_frame(16'h0200, 1, 3, 1'b0);
    check_frame("clampy", 3, 0, 32, 48, 0);

    // Zero step: every pixel samples (0,0); p4 is (1,1)
    run_frame(16'h0000, 2, 2, 1'b0);
    check_frame("step0", 4, 0, 0, 0, 0);
    check_eq("step0_p4", last_p4, 20);

    // Slow interpolator, spurious valid in FETCH, second go while in WAIT
    interp_lat = 10;
    spur_en    = 1'b1;
    run_frame(16'h0180, 2, 2, 1'b1);
    check_frame("hshake", 4, 0, 6, 24, 30);
    interp_lat = 3;
    spur_en    = 1'b0;

    // Reset after two writes
    base_wr = wr_d.size();
    go_pulse(16'h0180, 2, 2);
    k = 0;
    while (wr_d.size() - base_wr < 2 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("rstmid_two_writes", k < 500, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_outs_zero", |{o_busy, o_done, o_wr_en, ifc.o_start, o_rd_addr, o_wr_addr,
                                   o_wr_data, cur}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("rstmid_no_more_wr", wr_d.size() - base_wr, 2);
    run_frame(16'h0180, 2, 2, 1'b0);
    check_frame("after_rst", 4, 0, 6, 24, 30);

`ifdef BILINEAR_SEQ_TIMEOUT_EN
    never_valid = 1'b1;
    run_frame(16'h0180, 2, 1, 1'b0);
    check_frame("tmo", 2, 0, 0, 0, 0);
    check_eq("tmo_gap", (last_wr_cyc - start_cyc >= 16) && (last_wr_cyc - start_cyc <= 18), 1);
    check_eq("tmo_err_set", o_err, 1);
    never_valid = 1'b0;
    run_frame(16'h0180, 2, 1, 1'b0);
    check_frame("tmo_clr", 2, 0, 6, 0, 0);
    check_eq("tmo_err_clr", o_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
